wm8731_ctrl_responder: RTL and testbench
========================================

# wm8731_ctrl_responder

Synthesizable responder for the WM8731 2-wire (I2C-style) control interface: the receiving end of the frames our controller's bit/quarter-phase timing generator produces. It oversamples SCLK/SDIN with the system clock, detects START/STOP, shifts in the 24-bit write frame (device byte, two data bytes), drives ACKs and emits each decoded register write. It serves as the on-chip loopback target for controller bring-up and as the reference responder in the codec-controller benches.

## Interface

Parameters:
- DEV_ADDR, 7'h1A: 7-bit device address (CSB low); any other address is NACKed.
- SYNC_STAGES, 2: synchronizer depth for sclk and sdin; minimum 2.

Ports:
- clk  input  1  system clock; must be at least 8× the SCLK rate.
- reset  input  1  asynchronous, active-low reset (low = reset).
- sclk  input  1  bus clock from the controller.
- sdin  input  1  bus data, sampled value of the open-drain line.
- sdin_oe  output  1  1 = pull SDIN low (ACK); 0 = release.
- reg_addr  output  7  register address of the last accepted write.
- reg_data  output  9  data of the last accepted write.
- wr_valid  output  1  one-cycle pulse when reg_addr/reg_data update.
- busy  output  1  high from detected START to detected STOP.
- frame_err  output  1  one-cycle pulse on an aborted frame.

## Operation

- Each of sclk and sdin passes through a SYNC_STAGES flip-flop synchronizer plus one history register. Events are computed from synchronized values only:
  - START: sdin falls while sclk is high.
  - STOP: sdin rises while sclk is high.
  - Data is sampled on the sclk rising edge.
- FSM states:
  - IDLE -> DEV on START.
  - DEV: 8 bits, MSB first. At the 8th rising edge, compare {DEV_ADDR, 1'b0}; on a match go to ACK1, otherwise go to WAIT_STOP with no ACK driven. A read bit set to 1 counts as a mismatch.
  - ACK1 -> HI -> ACK2 -> LO -> ACK3 -> WAIT_STOP.
  - HI captures B15..B8, where B15..B9 = register address and B8 = data bit 8.
  - LO captures B7..B0.
- A 4-bit bit counter counts 0..7 within a byte and is cleared on entering each byte state.
- ACK drive: sdin_oe rises on the detected sclk falling edge that ends bit 8 of a byte. It falls on the detected sclk falling edge that ends the ACK clock. sdin_oe is never asserted in IDLE or WAIT_STOP.
- Commit: on the 8th rising edge in LO, the cycle after detection, reg_addr and reg_data load and wr_valid pulses once. This happens regardless of the later STOP.
- START in any non-IDLE state (repeated START) restarts at DEV. If it occurs while in DEV, HI or LO with a nonzero bit count, or in ACK1 or ACK2, frame_err also pulses.
- STOP in any state returns to IDLE and releases sdin_oe.
  - frame_err pulses if the STOP arrives before the commit, unless the state is WAIT_STOP reached through an address mismatch.
  - busy drops the same cycle.
- Reset (asynchronous, mid-frame allowed): FSM to IDLE. sdin_oe, wr_valid, busy and frame_err are 0. reg_addr and reg_data are 0. Synchronizers are cleared to 1, the bus idle level, so no false START follows reset release.

## Timing

- Pin-to-event latency: SYNC_STAGES+1 clk cycles. Events are detected on the cycle after the history register updates.
- wr_valid appears 1 clk after the 24th data bit's rising edge is detected, i.e. SYNC_STAGES+2 clk after the pin edge.
- sdin_oe changes 1 clk after the triggering sclk falling edge is detected.
- sclk high and low phases each must be at least SYNC_STAGES+2 clk. Data changes while sclk is high are legal only as START or STOP.
- Simultaneous sclk and sdin change in one clk sample: sclk takes priority. The sdin transition is then not treated as START or STOP.
- Outputs are registered. There are no combinational paths from pins to outputs.

## Structure

- Shared package wm8731_pkg holds:
  - WM_DEV_ADDR_CSB0 = 7'h1A and WM_DEV_ADDR_CSB1 = 7'h1B.
  - The FSM state enum (IDLE, DEV, ACK1, HI, ACK2, LO, ACK3, WAIT_STOP).
  - Register address constants 0x00..0x09 and 0x0F (reset register).
- Sub-module wm8731_edge_sync (synchronizer + history + rise/fall outputs), instanced once for sclk and once for sdin.
- Top level: FSM, bit counter, 8-bit shift register, address/data holding registers.

## Test plan

- Frame 0x34, 0x08, 0x12 with STOP -> sdin_oe low on all three ACK clocks; wr_valid once with reg_addr=0x04, reg_data=0x012; no frame_err.
- Frame 0x36 (address 0x1B) -> no ACK on any byte; no wr_valid; STOP -> busy low; frame_err stays 0.
- Frame 0x34, 0x1F, 0xFF -> reg_addr=0x0F, reg_data=0x1FF; then frame 0x34, 0x0C, 0x00 -> reg_addr=0x06, reg_data=0x000 with a second wr_valid pulse.
- STOP after 4 bits of the second byte -> frame_err pulse; sdin_oe 0; reg_addr/reg_data unchanged; the next full frame is accepted.
- Repeated START mid-HI followed by a full frame 0x34, 0x0E, 0x01 -> one frame_err pulse, then wr_valid with reg_addr=0x07, reg_data=0x001.
- Reset asserted while sdin_oe is 1 during ACK2 -> sdin_oe, busy and wr_valid are 0 immediately; no spurious START is detected after reset release with the bus idle high.

Source files
------------

// File: rtl/wm8731_pkg.sv
// Shared definitions for the WM8731 2-wire control responder:
// device addresses, FSM state encoding and codec register map.
package wm8731_pkg;

   localparam logic [6:0] WM_DEV_ADDR_CSB0 = 7'h1A;
   localparam logic [6:0] WM_DEV_ADDR_CSB1 = 7'h1B;

   localparam logic [6:0] WM_REG_LLINE  = 7'h00;
   localparam logic [6:0] WM_REG_RLINE  = 7'h01;
   localparam logic [6:0] WM_REG_LHP    = 7'h02;
   localparam logic [6:0] WM_REG_RHP    = 7'h03;
   localparam logic [6:0] WM_REG_APATH  = 7'h04;
   localparam logic [6:0] WM_REG_DPATH  = 7'h05;
   localparam logic [6:0] WM_REG_PWR    = 7'h06;
   localparam logic [6:0] WM_REG_IFACE  = 7'h07;
   localparam logic [6:0] WM_REG_SRATE  = 7'h08;
   localparam logic [6:0] WM_REG_ACTIVE = 7'h09;
   localparam logic [6:0] WM_REG_RESET  = 7'h0F;

   typedef enum logic [2:0] {
      IDLE,
      DEV,
      ACK1,
      HI,
      ACK2,
      LO,
      ACK3,
      WAIT_STOP
   } state_t;

endpackage

// File: rtl/wm8731_edge_sync.sv
// Multi-stage synchronizer plus history register for one bus pin.
// Reset value is the idle-high bus level so release never fakes an edge.
module wm8731_edge_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              hist;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '1;
         hist   <= 1'b1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         hist   <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~hist;
   assign fall  = ~level & hist;

endmodule

// File: rtl/wm8731_ctrl_responder.sv
// WM8731 2-wire control responder: decodes 24-bit write frames,
// drives ACKs and reports each accepted register write.
module wm8731_ctrl_responder
   import wm8731_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = WM_DEV_ADDR_CSB0,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sclk,
   input  logic       sdin,
   output logic       sdin_oe,
   output logic [6:0] reg_addr,
   output logic [8:0] reg_data,
   output logic       wr_valid,
   output logic       busy,
   output logic       frame_err
);

   logic   sclk_s, sclk_rise, sclk_fall;
   logic   sdin_s, sdin_rise, sdin_fall;
   logic   start_det, stop_det, last_bit;
   logic   commit_pend, clean_stop;
   logic [3:0] bit_cnt;
   logic [7:0] shift, hi_byte, byte_in;
   state_t state;

   wm8731_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk(clk), .reset(reset), .din(sclk),
      .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
   );

   wm8731_edge_sync #(.STAGES(SYNC_STAGES)) u_sdin_sync (
      .clk(clk), .reset(reset), .din(sdin),
      .level(sdin_s), .rise(sdin_rise), .fall(sdin_fall)
   );

   // An sclk edge in the same sample masks any sdin transition.
   assign start_det = sdin_fall & sclk_s & ~(sclk_rise | sclk_fall);
   assign stop_det  = sdin_rise & sclk_s & ~(sclk_rise | sclk_fall);
   assign byte_in   = {shift[6:0], sdin_s};
   assign last_bit  = (bit_cnt == 4'd7);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         bit_cnt     <= 4'd0;
         shift       <= 8'd0;
         hi_byte     <= 8'd0;
         commit_pend <= 1'b0;
         clean_stop  <= 1'b0;
         sdin_oe     <= 1'b0;
         reg_addr    <= 7'd0;
         reg_data    <= 9'd0;
         wr_valid    <= 1'b0;
         busy        <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         wr_valid  <= 1'b0;
         frame_err <= 1'b0;

         // The write lands one cycle after the last data bit, whatever the bus does next.
         if (commit_pend) begin
            commit_pend <= 1'b0;
            reg_addr    <= hi_byte[7:1];
            reg_data    <= {hi_byte[0], shift};
            wr_valid    <= 1'b1;
         end

         if (stop_det) begin
            if (state != IDLE && !clean_stop)
               frame_err <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
            sdin_oe <= 1'b0;
         end else if (start_det) begin
            if (((state == DEV || state == HI || state == LO) && bit_cnt != 4'd0)
                || state == ACK1 || state == ACK2)
               frame_err <= 1'b1;
            state      <= DEV;
            busy       <= 1'b1;
            sdin_oe    <= 1'b0;
            bit_cnt    <= 4'd0;
            clean_stop <= 1'b0;
         end else begin
            case (state)
               DEV, HI, LO: begin
                  if (sclk_rise) begin
                     shift   <= byte_in;
                     bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
                     if (last_bit) begin
                        if (state == DEV) begin
                           if (byte_in == {DEV_ADDR, 1'b0})
                              state <= ACK1;
                           else begin
                              state      <= WAIT_STOP;
                              clean_stop <= 1'b1;
                           end
                        end else if (state == HI) begin
                           hi_byte <= byte_in;
                           state   <= ACK2;
                        end else begin
                           commit_pend <= 1'b1;
                           clean_stop  <= 1'b1;
                           state       <= ACK3;
                        end
                     end
                  end
               end
               // First falling edge ends bit 8 and starts the ACK; the second ends the ACK clock.
               ACK1, ACK2, ACK3: begin
                  if (sclk_fall) begin
                     if (!sdin_oe)
                        sdin_oe <= 1'b1;
                     else begin
                        sdin_oe <= 1'b0;
                        bit_cnt <= 4'd0;
                        case (state)
                           ACK1:    state <= HI;
                           ACK2:    state <= LO;
                           default: state <= WAIT_STOP;
                        endcase
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wm8731_ctrl_responder.sv
// Self-checking bench: bit-bangs 2-wire frames into the responder and
// compares ACKs, writes and error pulses against a frame-level model.
module tb_wm8731_ctrl_responder;
   import wm8731_pkg::*;

   localparam int Q = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       sclk = 1'b1;
   logic       sdin_drv = 1'b1;
   logic       sdin_line;
   logic       sdin_oe;
   logic [6:0] reg_addr;
   logic [8:0] reg_data;
   logic       wr_valid;
   logic       busy;
   logic       frame_err;

   int compared = 0;
   int mismatched = 0;
   int wv_cnt = 0;
   int fe_cnt = 0;

   logic [6:0] model_addr = 7'd0;
   logic [8:0] model_data = 9'd0;

   assign sdin_line = sdin_drv & ~sdin_oe;

   wm8731_ctrl_responder dut (
      .clk(clk), .reset(reset), .sclk(sclk), .sdin(sdin_line),
      .sdin_oe(sdin_oe), .reg_addr(reg_addr), .reg_data(reg_data),
      .wr_valid(wr_valid), .busy(busy), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled on the edge opposite to the DUT's active edge.
   always @(negedge clk) begin
      if (wr_valid) wv_cnt++;
      if (frame_err) fe_cnt++;
   end

   task automatic ticks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      compared++;
      assert (obs === exp_v) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic sendBit(input logic b, output logic oe_mid);
      sdin_drv = b;
      ticks(Q);
      sclk = 1'b1;
      ticks(Q / 2);
      oe_mid = sdin_oe;
      ticks(Q / 2);
      sclk = 1'b0;
      ticks(2);
   endtask

   task automatic sendByte(input logic [7:0] b, output logic ack);
      logic dummy;
      for (int i = 7; i >= 0; i--) sendBit(b[i], dummy);
      sendBit(1'b1, ack);
   endtask

   task automatic sendStart();
      sdin_drv = 1'b0;
      ticks(Q);
      sclk = 1'b0;
      ticks(Q);
   endtask

   task automatic sendRepStart();
      sdin_drv = 1'b1;
      ticks(Q);
      sclk = 1'b1;
      ticks(Q);
      sdin_drv = 1'b0;
      ticks(Q);
      sclk = 1'b0;
      ticks(2);
   endtask

   task automatic sendStop();
      sdin_drv = 1'b0;
      ticks(Q);
      sclk = 1'b1;
      ticks(Q);
      sdin_drv = 1'b1;
      ticks(Q);
   endtask

   // Full three-byte frame; the model says a frame is accepted only when the
   // device byte is our write address, and then the write is addr/data split of bytes 2-3.
   task automatic applyStimulus(input string tag, input logic [7:0] dev, input logic [7:0] b1, input logic [7:0] b2);
      int wv0, fe0;
      logic a0, a1, a2, exp_ack;
      wv0 = wv_cnt;
      fe0 = fe_cnt;
      exp_ack = (dev == {WM_DEV_ADDR_CSB0, 1'b0});
      sendStart();
      checkOutput({tag, " busy_mid"}, 16'(busy), 16'd1);
      sendByte(dev, a0);
      sendByte(b1, a1);
      sendByte(b2, a2);
      sendStop();
      ticks(4);
      if (exp_ack) begin
         model_addr = b1[7:1];
         model_data = {b1[0], b2};
      end
      checkOutput({tag, " acks"}, 16'({a0, a1, a2}), exp_ack ? 16'h7 : 16'h0);
      checkOutput({tag, " wr_pulses"}, 16'(wv_cnt - wv0), exp_ack ? 16'd1 : 16'd0);
      checkOutput({tag, " frame_err"}, 16'(fe_cnt - fe0), 16'd0);
      checkOutput({tag, " reg_addr"}, 16'(reg_addr), 16'(model_addr));
      checkOutput({tag, " reg_data"}, 16'(reg_data), 16'(model_data));
      checkOutput({tag, " busy_end"}, 16'(busy), 16'd0);
   endtask

   initial begin
      logic ack, dummy;
      int wv0, fe0;
      logic [7:0] dev, b1, b2;

      $display("[TB] reset state");
      ticks(3);
      checkOutput("rst sdin_oe", 16'(sdin_oe), 16'd0);
      checkOutput("rst busy", 16'(busy), 16'd0);
      checkOutput("rst wr_valid", 16'(wr_valid), 16'd0);
      checkOutput("rst frame_err", 16'(frame_err), 16'd0);
      checkOutput("rst reg_addr", 16'(reg_addr), 16'd0);
      checkOutput("rst reg_data", 16'(reg_data), 16'd0);
      reset = 1'b1;
      ticks(10);

      $display("[TB] directed frames");
      applyStimulus("apath", 8'h34, 8'h08, 8'h12);
      checkOutput("apath addr const", 16'(reg_addr), 16'(WM_REG_APATH));
      applyStimulus("csb1", {WM_DEV_ADDR_CSB1, 1'b0}, 8'h08, 8'h12);
      applyStimulus("reset_reg", 8'h34, 8'h1F, 8'hFF);
      checkOutput("reset_reg addr const", 16'(reg_addr), 16'(WM_REG_RESET));
      applyStimulus("pwr", 8'h34, 8'h0C, 8'h00);

      $display("[TB] STOP after 4 bits of second byte");
      wv0 = wv_cnt;
      fe0 = fe_cnt;
      sendStart();
      sendByte(8'h34, ack);
      for (int i = 0; i < 4; i++) sendBit(1'b1, dummy);
      sendStop();
      ticks(4);
      checkOutput("abort frame_err", 16'(fe_cnt - fe0), 16'd1);
      checkOutput("abort wr_pulses", 16'(wv_cnt - wv0), 16'd0);
      checkOutput("abort sdin_oe", 16'(sdin_oe), 16'd0);
      checkOutput("abort reg_addr", 16'(reg_addr), 16'(model_addr));
      checkOutput("abort reg_data", 16'(reg_data), 16'(model_data));
      applyStimulus("after_abort", 8'h34, 8'h10, 8'h5A);

      $display("[TB] repeated START mid-HI");
      wv0 = wv_cnt;
      fe0 = fe_cnt;
      sendStart();
      sendByte(8'h34, ack);
      for (int i = 0; i < 3; i++) sendBit(1'b0, dummy);
      sendRepStart();
      sendByte(8'h34, ack);
      sendByte(8'h0E, ack);
      sendByte(8'h01, ack);
      sendStop();
      ticks(4);
      model_addr = WM_REG_IFACE;
      model_data = 9'h001;
      checkOutput("rs frame_err", 16'(fe_cnt - fe0), 16'd1);
      checkOutput("rs wr_pulses", 16'(wv_cnt - wv0), 16'd1);
      checkOutput("rs reg_addr", 16'(reg_addr), 16'(model_addr));
      checkOutput("rs reg_data", 16'(reg_data), 16'(model_data));

      $display("[TB] randomized frames");
      for (int n = 0; n < 8; n++) begin
         dev = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h34;
         b1 = 8'($urandom);
         b2 = 8'($urandom);
         applyStimulus($sformatf("rnd%0d", n), dev, b1, b2);
      end

      $display("[TB] reset during ACK2");
      fe0 = fe_cnt;
      sendStart();
      sendByte(8'h34, ack);
      for (int i = 7; i >= 0; i--) sendBit(1'(8'h0A >> i), dummy);
      sdin_drv = 1'b1;
      ticks(Q);
      sclk = 1'b1;
      ticks(Q / 2);
      checkOutput("ack2 sdin_oe", 16'(sdin_oe), 16'd1);
      reset = 1'b0;
      #1;
      checkOutput("rstack sdin_oe", 16'(sdin_oe), 16'd0);
      checkOutput("rstack busy", 16'(busy), 16'd0);
      checkOutput("rstack wr_valid", 16'(wr_valid), 16'd0);
      model_addr = 7'd0;
      model_data = 9'd0;
      ticks(Q / 2);
      sclk = 1'b0;
      ticks(Q);
      sclk = 1'b1;
      ticks(2);
      reset = 1'b1;
      ticks(20);
      checkOutput("post_rst busy", 16'(busy), 16'd0);
      checkOutput("post_rst frame_err", 16'(fe_cnt - fe0), 16'd0);
      checkOutput("post_rst reg_addr", 16'(reg_addr), 16'd0);
      applyStimulus("post_rst", 8'h34, 8'h12, 8'h97);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
